divmod_axis: RTL and testbench

DIVMOD_AXIS -- requirements
Module: divmod_axis

---
 rtl/divmod_axis.sv | 144 ++++++++++++++
 tb/tb_divmod_axis.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/divmod_axis.sv
// divmod_axis -- constant-time unsigned restoring divider with AXI-Stream style
// handshakes.
//
// Purpose : floor(dividend/divisor) and dividend mod divisor. One quotient bit
//           is produced per clock. A zero divisor bypasses the iteration and
//           returns all-ones / 0 with output_tuser set.
// Ports   :
//   clk, rst                     clock; synchronous active-high reset
//   input_dividen_tdata/tvalid/tready   dividend stream (DIVIDEND_W)
//   input_divisor_tdata/tvalid/tready   divisor stream  (DIVISOR_W)
//   output_quotient_tdata        quotient (DIVIDEND_W)
//   output_remainder_tdata       remainder (DIVISOR_W)
//   output_tuser                 divide-by-zero flag
//   output_tvalid/tready         result handshake
module divmod_axis #(
  parameter int DIVIDEND_W = 128,
  parameter int DIVISOR_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIVIDEND_W-1:0] input_dividen_tdata,
  input  logic                  input_dividen_tvalid,
  output logic                  input_dividen_tready,
  input  logic [DIVISOR_W-1:0]  input_divisor_tdata,
  input  logic                  input_divisor_tvalid,
  output logic                  input_divisor_tready,
  output logic [DIVIDEND_W-1:0] output_quotient_tdata,
  output logic [DIVISOR_W-1:0]  output_remainder_tdata,
  output logic                  output_tuser,
  output logic                  output_tvalid,
  input  logic                  output_tready
);

  localparam int CW = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                r_state, w_next;
  logic [DIVIDEND_W-1:0] r_dq;       // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W:0]    r_rem;      // partial remainder
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [CW-1:0]         r_cnt;
  logic                  r_fin;      // all quotient bits produced; publish next edge
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem_o;
  logic                  r_tuser;

  logic                  w_accept;
  logic                  w_div_zero;
  logic [DIVISOR_W:0]    w_shift;
  logic [DIVISOR_W:0]    w_diff;
  logic                  w_ge;

  // Both operands move together; a lone valid never transfers.
  assign w_accept   = (r_state == IDLE) & input_dividen_tvalid & input_divisor_tvalid;
  assign w_div_zero = (input_divisor_tdata == '0);

  // Restoring step: bring in the next dividend MSB, subtract when it fits.
  // The top remainder bit is always 0 after a step; it is folded into the
  // compare so a set bit would still mean "larger than the divisor".
  assign w_shift = {r_rem[DIVISOR_W-1:0], r_dq[DIVIDEND_W-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_ge    = r_rem[DIVISOR_W] | (w_shift >= {1'b0, r_divisor});

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // ---- next state ----
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_div_zero ? DONE : CALC;
      CALC:    if (r_fin) w_next = DONE;
      DONE:    if (output_tready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    input_dividen_tready = 1'b0;
    input_divisor_tready = 1'b0;
    // Each ready mirrors the other side's valid so neither side is told it
    // transferred unless the joint transfer actually happens.
    if (!rst && r_state == IDLE) begin
      input_dividen_tready = input_divisor_tvalid;
      input_divisor_tready = input_dividen_tvalid;
    end
    output_tvalid = (r_state == DONE);
  end

  assign output_quotient_tdata  = r_quot;
  assign output_remainder_tdata = r_rem_o;
  assign output_tuser           = r_tuser;

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dq      <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_fin     <= 1'b0;
      r_quot    <= '0;
      r_rem_o   <= '0;
      r_tuser   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_div_zero) begin
              r_quot  <= '1;
              r_rem_o <= '0;
              r_tuser <= 1'b1;
            end else begin
              r_dq      <= input_dividen_tdata;
              r_divisor <= input_divisor_tdata;
              r_rem     <= '0;
              r_cnt     <= CW'(DIVIDEND_W - 1);
              r_fin     <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!r_fin) begin
            r_rem <= w_ge ? w_diff : w_shift;
            r_dq  <= {r_dq[DIVIDEND_W-2:0], w_ge};
            r_fin <= (r_cnt == '0);
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end else begin
            r_quot  <= r_dq;
            r_rem_o <= r_rem[DIVISOR_W-1:0];
            r_tuser <= 1'b0;
          end
        end
        default: ;  // DONE: results held until the handshake
      endcase
    end
  end

endmodule

// File: tb/tb_divmod_axis.sv
// tb_divmod_axis -- randomized + directed check of divmod_axis against a
// plain-arithmetic model (a/b, a%b, zero-divisor rule).
module tb_divmod_axis;

  localparam int AW = 128;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a_d;
  logic          a_v;
  logic          a_r;
  logic [BW-1:0] b_d;
  logic          b_v;
  logic          b_r;
  logic [AW-1:0] o_q;
  logic [BW-1:0] o_rm;
  logic          o_u;
  logic          o_v;
  logic          o_r;

  int n_vec = 0;
  int n_err = 0;

  divmod_axis #(.DIVIDEND_W(AW), .DIVISOR_W(BW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .input_dividen_tdata    (a_d),
    .input_dividen_tvalid   (a_v),
    .input_dividen_tready   (a_r),
    .input_divisor_tdata    (b_d),
    .input_divisor_tvalid   (b_v),
    .input_divisor_tready   (b_r),
    .output_quotient_tdata  (o_q),
    .output_remainder_tdata (o_rm),
    .output_tuser           (o_u),
    .output_tvalid          (o_v),
    .output_tready          (o_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction. skew>0: dividend valid first for skew cycles;
  // skew<0: divisor valid first. bp: cycles of held-off output_tready in DONE.
  task automatic do_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                       input int skew, input int bp);
    logic [AW-1:0] eq;
    logic [BW-1:0] er;
    logic          eu;
    int            lat;
    int            exp_lat;
    if (b == '0) begin
      eq = '1; er = '0; eu = 1'b1;
      exp_lat = 0;            // goes to DONE on the accepting edge itself
    end else begin
      eq = a / AW'(b);
      er = BW'(a % AW'(b));
      eu = 1'b0;
      exp_lat = AW + 1;
    end
    o_r = 1'b0;
    a_d = a;
    b_d = b;
    if (skew > 0) begin
      a_v = 1'b1;
      repeat (skew) begin
        tick;
        chk("lone_dvd_rdy", AW'(a_r), 0);
        chk("lone_dvd_vld", AW'(o_v), 0);
      end
    end else if (skew < 0) begin
      b_v = 1'b1;
      repeat (-skew) begin
        tick;
        chk("lone_dvs_rdy", AW'(b_r), 0);
        chk("lone_dvs_vld", AW'(o_v), 0);
      end
    end
    a_v = 1'b1;
    b_v = 1'b1;
    #1;
    chk("joint_rdy", AW'({a_r, b_r}), 3);
    tick;                                  // accepting edge
    a_v = 1'b0;
    b_v = 1'b0;
    a_d = {$urandom, $urandom, $urandom, $urandom};
    b_d = {$urandom, $urandom};
    #1;
    chk("busy_rdy", AW'({a_r, b_r}), 0);
    lat = 0;
    while (!o_v && lat < 400) begin
      o_r = 1'($urandom);                  // must be ignored while calculating
      tick;
      lat++;
    end
    o_r = 1'b0;
    chk("latency", AW'(lat), AW'(exp_lat));
    chk("quot", o_q, eq);
    chk("rem", AW'(o_rm), AW'(er));
    chk("tuser", AW'(o_u), AW'(eu));
    if (bp > 0) begin
      a_v = 1'b1;
      b_v = 1'b1;
      repeat (bp) begin
        tick;
        chk("bp_vld", AW'(o_v), 1);
        chk("bp_quot", o_q, eq);
        chk("bp_rem", AW'(o_rm), AW'(er));
        chk("bp_rdy", AW'({a_r, b_r}), 0);
      end
      a_v = 1'b0;
      b_v = 1'b0;
    end
    o_r = 1'b1;
    tick;
    o_r = 1'b0;
    #1;
    chk("post_hs_vld", AW'(o_v), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [BW-1:0] b;
    rst = 1'b1;
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = '0;
    b_d = '0;
    o_r = 1'b0;
    repeat (3) tick;
    chk("rst_vld", AW'(o_v), 0);
    chk("rst_user", AW'(o_u), 0);
    chk("rst_quot", o_q, 0);
    chk("rst_rem", AW'(o_rm), 0);
    chk("rst_rdy", AW'({a_r, b_r}), 0);
    rst = 1'b0;
    a_v = 1'b1;
    b_v = 1'b0;
    #1;
    chk("post_rst_rdy", AW'({a_r, b_r}), 1);   // divisor ready mirrors dividend valid
    a_v = 1'b0;
    tick;

    // Directed cases
    do_op(AW'(100), BW'(7), 0, 0);
    do_op(AW'(5), BW'(9), 0, 1);
    do_op('1, BW'(1), 0, 0);
    do_op('1, '1, 0, 0);
    do_op(AW'(42), BW'(0), 0, 1);
    do_op(AW'(77), BW'(5), 0, 20);
    do_op(AW'(1000), BW'(13), 5, 0);

    // Reset in the middle of CALC: result must never appear
    a_d = AW'(100); b_d = BW'(7);
    a_v = 1'b1; b_v = 1'b1;
    tick;
    a_v = 1'b0; b_v = 1'b0;
    repeat (60) tick;
    rst = 1'b1;
    a_v = 1'b1; b_v = 1'b1;
    #1;
    chk("mid_rst_rdy", AW'({a_r, b_r}), 0);
    tick;
    chk("mid_rst_vld", AW'(o_v), 0);
    rst = 1'b0;
    a_v = 1'b0; b_v = 1'b0;
    seen = 0;
    repeat (200) begin
      tick;
      if (o_v) seen++;
    end
    chk("abort_no_out", AW'(seen), 0);
    do_op(AW'(100), BW'(7), 0, 2);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      case ($urandom % 8)
        0:       b = '0;
        1:       b = BW'(1);
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      do_op({$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127), b,
            int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
